spi_master: RTL

- SPI master that drives the RAM-bridge SPI slave from the host side.
- Accepts one command per valid/ready handshake and serialises it as a 10-bit frame {op[1:0], data[7:0]} on MOSI.
- For read-data commands (op=11), also captures the 8-bit reply on MISO and presents it on rd_data.
- Shifts one bit per clk. The slave runs on the same clk, so no SCLK is generated.

---
 rtl/spi_master.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// ----------------------------------------------------------------------------
// spi_master
//   Host-side SPI master for the RAM-bridge SPI slave. One command per
//   valid/ready handshake is sent MSB first on MOSI as a 10-bit frame
//   {op[1:0], data[7:0]}, preceded by a lead bit equal to op[1].
//   Read-data frames (op = 2'b11) then wait RD_LATENCY turnaround cycles and
//   capture an 8-bit reply from MISO, presented on rd_data with a one-cycle
//   rd_valid pulse. The slave shares clk, so no SCLK is generated.
//
//   Optional build macro: SPI_MASTER_SEQ_CHECK_EN
//     When defined, the master tracks the last accepted op and pulses
//     seq_err one cycle after acceptance of an out-of-order command.
//     When undefined, seq_err is tied low.
// ----------------------------------------------------------------------------
module spi_master #(
    parameter int unsigned RD_LATENCY = 2,  // turnaround cycles, 1..15
    parameter int unsigned GAP_CYCLES = 1   // minimum SS_n-high cycles, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_TURN,
        ST_RECV,
        ST_GAP
    } state_e;

    localparam logic [1:0] OP_RD_DATA = 2'b11;
    localparam logic [3:0] SHIFT_LAST = 4'd9;
    localparam logic [3:0] RECV_LAST  = 4'd7;
    localparam logic [3:0] TURN_LAST  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_e     state_q;
    logic [3:0] cnt_q;        // shared bit / turnaround / gap counter
    logic [9:0] tx_q;         // outgoing word, shifted left as bits leave
    logic       rd_frame_q;   // current frame is a read-data frame
    logic [7:0] rx_q;         // incoming reply, MISO enters at the LSB
    logic       ss_n_q;
    logic       mosi_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;

    logic       accept;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_ready && cmd_valid;

    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Frame sequencer: walks one command through lead bit, shift, optional
    // turnaround/receive, then the inter-frame gap; all pin outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is assigned with <= so every register
            // samples pre-edge values, independent of statement order.
            state_q    <= ST_GAP;
            cnt_q      <= '0;
            tx_q       <= '0;
            rd_frame_q <= 1'b0;
            rx_q       <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        tx_q       <= {cmd_op, cmd_data};
                        rd_frame_q <= (cmd_op == OP_RD_DATA);
                        ss_n_q     <= 1'b0;
                        mosi_q     <= cmd_op[1];
                        cnt_q      <= '0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    mosi_q  <= tx_q[9];
                    tx_q    <= {tx_q[8:0], 1'b0};
                    cnt_q   <= '0;
                    state_q <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (cnt_q == SHIFT_LAST) begin
                        mosi_q <= 1'b0;
                        cnt_q  <= '0;
                        if (rd_frame_q) begin
                            state_q <= ST_TURN;
                        end else begin
                            ss_n_q  <= 1'b1;
                            state_q <= ST_GAP;
                        end
                    end else begin
                        mosi_q <= tx_q[9];
                        tx_q   <= {tx_q[8:0], 1'b0};
                        cnt_q  <= cnt_q + 4'd1;
                    end
                end

                ST_TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_RECV;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                ST_RECV: begin
                    rx_q <= {rx_q[6:0], MISO};
                    if (cnt_q == RECV_LAST) begin
                        rd_data_q  <= {rx_q[6:0], MISO};
                        rd_valid_q <= 1'b1;
                        ss_n_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                default: begin
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_GAP;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic [1:0] last_op_q;
    logic       have_last_q;
    logic       seq_err_q;
    logic       seq_err_d;

    // Legality of the op being offered against the last accepted op.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch
        // is inferred.
        seq_err_d = 1'b0;
        if (cmd_op == 2'b01) begin
            seq_err_d = !(have_last_q && !last_op_q[1]);
        end else if (cmd_op == OP_RD_DATA) begin
            seq_err_d = !(have_last_q && (last_op_q == 2'b10));
        end
    end

    // Op history and one-cycle error pulse, updated only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_op_q   <= '0;
            have_last_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            if (accept) begin
                seq_err_q   <= seq_err_d;
                last_op_q   <= cmd_op;
                have_last_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule
